// File: rtl/eth_pe_checksum_insert.sv
// Store-and-forward header buffer that replays a captured IP/ICMP header with the
// generator's checksum written big-endian at a programmable byte offset.
module eth_pe_checksum_insert #(
  parameter int unsigned BUF_DEPTH = 64,
  parameter int unsigned ADDR_W    = 6
) (
  input  logic              pe_clk,
  input  logic              pe_rstn,
  input  logic              pe_logic_clr,
  input  logic              in_start,
  input  logic [ADDR_W-1:0] cksum_offset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [15:0]       hw_checksum_in,
  input  logic              hw_checksum_done,
  output logic              out_valid,
  output logic [7:0]        out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              insert_done,
  output logic              err_overflow,
  output logic              err_offset
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic [15:0]       cksum_q, cksum_d;
  logic              cksum_seen_q, cksum_seen_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              insert_done_q, insert_done_d;
  logic              err_overflow_q, err_overflow_d;
  logic              err_offset_q, err_offset_d;
  logic              mem_we_c;
  logic              load_c;
  logic              accept_c;
  logic              buf_full_c;
  logic [7:0]        hdr_mem_q [BUF_DEPTH];

  assign buf_full_c = (wr_ptr_q == CNT_W'(BUF_DEPTH));
  assign accept_c   = out_valid_q & out_ready;

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    len_d          = len_q;
    off_d          = off_q;
    cksum_d        = cksum_q;
    cksum_seen_d   = cksum_seen_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_last_d     = out_last_q;
    insert_done_d  = insert_done_q;
    err_overflow_d = err_overflow_q;
    err_offset_d   = err_offset_q;
    mem_we_c       = 1'b0;
    load_c         = 1'b0;

    // First done pulse seen outside IDLE wins; later changes on the bus are ignored.
    if (state_q != S_IDLE && hw_checksum_done && !cksum_seen_q) begin
      cksum_d      = hw_checksum_in;
      cksum_seen_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (in_start) begin
          wr_ptr_d       = '0;
          err_overflow_d = 1'b0;
          err_offset_d   = 1'b0;
          insert_done_d  = 1'b0;
          cksum_seen_d   = 1'b0;
          off_d          = cksum_offset;
          state_d        = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (in_valid) begin
          if (buf_full_c) begin
            err_overflow_d = 1'b1;
          end else begin
            mem_we_c = 1'b1;
            wr_ptr_d = wr_ptr_q + CNT_W'(1);
          end
          if (in_last) begin
            len_d   = buf_full_c ? wr_ptr_q : wr_ptr_q + CNT_W'(1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cksum_seen_q || hw_checksum_done) begin
          err_offset_d = ((CNT_W'(off_q) + CNT_W'(1)) >= len_q);
          rd_ptr_d     = '0;
          state_d      = S_DRAIN;
        end
      end
      default: begin
        load_c = (!out_valid_q || out_ready) && (rd_ptr_q < len_q);
        if (load_c) begin
          out_valid_d = 1'b1;
          out_last_d  = (rd_ptr_q == len_q - CNT_W'(1));
          rd_ptr_d    = rd_ptr_q + CNT_W'(1);
          if (!err_offset_q && rd_ptr_q == CNT_W'(off_q)) begin
            out_data_d = cksum_q[15:8];
          end else if (!err_offset_q && rd_ptr_q == CNT_W'(off_q) + CNT_W'(1)) begin
            out_data_d = cksum_q[7:0];
          end else begin
            out_data_d = hdr_mem_q[rd_ptr_q[ADDR_W-1:0]];
          end
        end else if (accept_c) begin
          out_valid_d = 1'b0;
        end
        if (accept_c && out_last_q) begin
          out_valid_d   = 1'b0;
          out_last_d    = 1'b0;
          insert_done_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
    endcase

    // Synchronous clear aborts any capture or drain without emitting out_last.
    if (pe_logic_clr) begin
      state_d        = S_IDLE;
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      len_d          = '0;
      off_d          = '0;
      cksum_d        = '0;
      cksum_seen_d   = 1'b0;
      out_valid_d    = 1'b0;
      out_data_d     = '0;
      out_last_d     = 1'b0;
      insert_done_d  = 1'b0;
      err_overflow_d = 1'b0;
      err_offset_d   = 1'b0;
      mem_we_c       = 1'b0;
    end

    in_ready_d = (state_d == S_CAPTURE);
  end

  always_ff @(posedge pe_clk or negedge pe_rstn) begin
    if (!pe_rstn) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      len_q          <= '0;
      off_q          <= '0;
      cksum_q        <= '0;
      cksum_seen_q   <= 1'b0;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_last_q     <= 1'b0;
      insert_done_q  <= 1'b0;
      err_overflow_q <= 1'b0;
      err_offset_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      len_q          <= len_d;
      off_q          <= off_d;
      cksum_q        <= cksum_d;
      cksum_seen_q   <= cksum_seen_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_last_q     <= out_last_d;
      insert_done_q  <= insert_done_d;
      err_overflow_q <= err_overflow_d;
      err_offset_q   <= err_offset_d;
    end
  end

  // Header storage only; no reset needed since reads never pass the captured length.
  always_ff @(posedge pe_clk) begin
    if (mem_we_c) begin
      hdr_mem_q[wr_ptr_q[ADDR_W-1:0]] <= in_data;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_last     = out_last_q;
  assign insert_done  = insert_done_q;
  assign err_overflow = err_overflow_q;
  assign err_offset   = err_offset_q;

endmodule

// File: tb/tb_eth_pe_checksum_insert.sv
// Scoreboard bench for eth_pe_checksum_insert: a reference model queues the expected
// output bytes per header and a monitor pops and compares every accepted byte.
module tb_eth_pe_checksum_insert;

  localparam int DEPTH = 64;

  logic        pe_clk = 1'b0;
  logic        pe_rstn;
  logic        pe_logic_clr;
  logic        in_start;
  logic [5:0]  cksum_offset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic [15:0] hw_checksum_in;
  logic        hw_checksum_done;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic        insert_done;
  logic        err_overflow;
  logic        err_offset;

  eth_pe_checksum_insert #(.BUF_DEPTH(64), .ADDR_W(6)) dut (
    .pe_clk(pe_clk), .pe_rstn(pe_rstn), .pe_logic_clr(pe_logic_clr),
    .in_start(in_start), .cksum_offset(cksum_offset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .hw_checksum_in(hw_checksum_in), .hw_checksum_done(hw_checksum_done),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .insert_done(insert_done), .err_overflow(err_overflow), .err_offset(err_offset)
  );

  always #5 pe_clk = ~pe_clk;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_q [$];
  logic [7:0]  pkt [$];
  int          rdy_mode = 0;
  int          acc_cnt = 0;
  int          first_v_cyc = -1;
  logic        seen_v = 1'b0;
  logic        hold_v = 1'b0;
  logic [7:0]  hold_d;
  logic        hold_l;
  logic [8:0]  mon_e;

  always @(posedge pe_clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Downstream ready pattern: 0 always, 1 toggle, 2 random, else held low.
  always @(posedge pe_clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: stall stability plus in-order comparison of every accepted byte.
  always @(negedge pe_clk) begin
    if (hold_v) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(hold_d));
      chk("stall_last", 32'(out_last), 32'(hold_l));
    end
    if (out_valid && !seen_v) begin
      seen_v      = 1'b1;
      first_v_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %0h expected none", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(mon_e[7:0]));
        chk("out_last", 32'(out_last), 32'(mon_e[8]));
      end
      acc_cnt++;
    end
    hold_v = out_valid && !out_ready;
    hold_d = out_data;
    hold_l = out_last;
  end

  // Reference model: keep the first DEPTH bytes, patch two bytes big-endian unless they don't fit.
  task automatic push_expected(input int off, input logic [15:0] ck, output logic eo);
    int         stored;
    logic [7:0] b;
    stored = (pkt.size() > DEPTH) ? DEPTH : pkt.size();
    eo     = (off + 1 >= stored);
    for (int i = 0; i < stored; i++) begin
      b = pkt[i];
      if (!eo && i == off)          b = ck[15:8];
      else if (!eo && i == off + 1) b = ck[7:0];
      exp_q.push_back({(i == stored - 1), b});
    end
  endtask

  task automatic feed(input int off, input logic [15:0] ck, input int early,
                      output int last_cyc, output int done_cyc);
    int n;
    n        = pkt.size();
    done_cyc = -1;
    @(posedge pe_clk); #1;
    in_start       = 1'b1;
    cksum_offset   = 6'(off);
    hw_checksum_in = ck;
    @(posedge pe_clk); #1;
    in_start = 1'b0;
    seen_v   = 1'b0;
    chk("insert_done_cleared", 32'(insert_done), 32'd0);
    chk("in_ready_capture", 32'(in_ready), 32'd1);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = pkt[i];
      in_last  = (i == n - 1);
      if (early > 0 && i == n - 1 - early) begin
        hw_checksum_done = 1'b1;
        done_cyc         = cyc;
      end
      last_cyc = cyc;
      @(posedge pe_clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_pkt(input int off, input logic [15:0] ck, input int early,
                         input int late_dly, input int mode);
    logic eo;
    int   last_cyc, done_cyc, exp_first, n;
    n        = pkt.size();
    rdy_mode = mode;
    push_expected(off, ck, eo);
    feed(off, ck, early, last_cyc, done_cyc);
    if (early == 0) begin
      repeat (late_dly) begin
        @(posedge pe_clk); #1;
      end
      hw_checksum_done = 1'b1;
      done_cyc         = cyc;
      exp_first        = done_cyc + 2;
    end else begin
      exp_first = last_cyc + 3;
    end
    for (int t = 0; t < 4000 && !insert_done; t++) begin
      @(posedge pe_clk); #1;
      if (t == 0) hw_checksum_in = ~ck;
    end
    if (!insert_done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got insert_done=0 expected 1");
    end
    chk("first_valid_cycle", 32'(first_v_cyc), 32'(exp_first));
    chk("insert_done", 32'(insert_done), 32'd1);
    chk("err_overflow", 32'(err_overflow), 32'(n > DEPTH));
    chk("err_offset", 32'(err_offset), 32'(eo));
    chk("bytes_outstanding", 32'(exp_q.size()), 32'd0);
    hw_checksum_done = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_clr();
    logic eo;
    int   last_cyc, done_cyc, base;
    rdy_mode = 0;
    pkt.delete();
    for (int i = 0; i < 20; i++) pkt.push_back(8'($urandom));
    push_expected(10, 16'h1234, eo);
    feed(10, 16'h1234, 0, last_cyc, done_cyc);
    hw_checksum_done = 1'b1;
    base = acc_cnt;
    for (int t = 0; t < 200 && acc_cnt < base + 5; t++) begin
      @(negedge pe_clk); #1;
    end
    chk("clr_bytes_before", 32'(acc_cnt - base), 32'd5);
    pe_logic_clr = 1'b1;
    rdy_mode     = 3;
    @(posedge pe_clk); #1;
    pe_logic_clr = 1'b0;
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_out_last", 32'(out_last), 32'd0);
    chk("clr_insert_done", 32'(insert_done), 32'd0);
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    chk("clr_out_data", 32'(out_data), 32'd0);
    hw_checksum_done = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge pe_clk);
    #1;
    chk("clr_idle_valid", 32'(out_valid), 32'd0);
  endtask

  logic [7:0] ipv4 [20];
  logic [7:0] icmp [8];

  initial begin
    int len, off, early, mode, late;
    ipv4 = '{8'h45, 8'h00, 8'h00, 8'h3c, 8'h1c, 8'h46, 8'h40, 8'h00, 8'h40, 8'h06,
             8'h00, 8'h00, 8'hac, 8'h10, 8'h0a, 8'h63, 8'hac, 8'h10, 8'h0a, 8'h0c};
    icmp = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00, 8'h01};
    pe_rstn = 1'b0; pe_logic_clr = 1'b0; in_start = 1'b0; cksum_offset = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; hw_checksum_in = '0;
    hw_checksum_done = 1'b0; out_ready = 1'b0;
    rdy_mode = 3;
    repeat (3) @(posedge pe_clk);
    #1 pe_rstn = 1'b1;
    @(posedge pe_clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_insert_done", 32'(insert_done), 32'd0);
    chk("rst_err_overflow", 32'(err_overflow), 32'd0);
    chk("rst_err_offset", 32'(err_offset), 32'd0);

    pkt.delete(); foreach (ipv4[i]) pkt.push_back(ipv4[i]);
    run_pkt(10, 16'hB1E6, 0, 2, 0);
    pkt.delete(); foreach (ipv4[i]) pkt.push_back(ipv4[i]);
    run_pkt(10, 16'hB1E6, 3, 0, 0);
    pkt.delete(); foreach (icmp[i]) pkt.push_back(icmp[i]);
    run_pkt(2, 16'hF7FD, 0, 1, 1);
    pkt.delete(); for (int i = 0; i < 70; i++) pkt.push_back(8'($urandom));
    run_pkt(10, 16'($urandom), 0, 1, 2);
    pkt.delete(); for (int i = 0; i < 4; i++) pkt.push_back(8'($urandom));
    run_pkt(3, 16'hABCD, 0, 0, 0);
    pkt.delete(); pkt.push_back(8'h5a);
    run_pkt(0, 16'h0102, 0, 1, 1);
    pkt.delete(); for (int i = 0; i < 6; i++) pkt.push_back(8'($urandom));
    run_pkt(4, 16'hC3D4, 0, 1, 2);

    run_clr();
    pkt.delete(); foreach (ipv4[i]) pkt.push_back(ipv4[i]);
    run_pkt(10, 16'hB1E6, 0, 1, 0);

    for (int k = 0; k < 10; k++) begin
      len   = $urandom_range(1, 64);
      off   = $urandom_range(0, (len > 63) ? 63 : len);
      early = (len > 4 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
      mode  = $urandom_range(0, 2);
      late  = $urandom_range(0, 3);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
      run_pkt(off, 16'($urandom), early, late, mode);
    end

    repeat (4) @(posedge pe_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

endmodule
